// File: rtl/frame_loader.sv
// Frame loader: parses a SYNC/width/height header followed by RGB332 pixels, fills the frame RAM
// and serves the scan-out read port. The image extent is published only once a full image has landed.
module frame_loader #(
    parameter int          DEPTH  = 8192,
    parameter int          ADDR_W = 13,
    parameter logic [7:0]  SYNC   = 8'hA5
) (
    input  logic              clk25,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pixel_addr,
    output logic [7:0]        pixel_data,
    output logic [7:0]        sx,
    output logic [7:0]        sy,
    output logic              frame_done,
    output logic              load_err
);

    typedef enum logic [2:0] {IDLE, GET_W, GET_H, LOAD, COMMIT, ERR} state_t;

    state_t            state, state_nx;
    logic              rdy_en;
    logic              accept;
    logic [7:0]        w_q, h_q;
    logic [15:0]       n_q, prod;
    logic [ADDR_W-1:0] wr_addr;
    logic              header_bad, last_px;
    logic [7:0]        mem [DEPTH];

    assign accept     = in_valid & in_ready;
    assign prod       = {8'd0, w_q} * {8'd0, in_data};
    assign header_bad = (w_q == 8'd0) || (in_data == 8'd0) || (prod > 16'(DEPTH));
    assign last_px    = (16'(wr_addr) == n_q - 16'd1);

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept && in_data == SYNC) state_nx = GET_W;
            GET_W:   if (accept) state_nx = GET_H;
            GET_H:   if (accept) state_nx = header_bad ? ERR : LOAD;
            LOAD:    if (accept && last_px) state_nx = COMMIT;
            COMMIT:  state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = 1'b0;
        frame_done = 1'b0;
        load_err   = 1'b0;
        unique case (state)
            IDLE, GET_W, GET_H, LOAD: in_ready = rdy_en;
            COMMIT:                   frame_done = 1'b1;
            ERR:                      load_err = 1'b1;
            default:                  in_ready = 1'b0;
        endcase
    end

    // rdy_en holds in_ready low until the first edge after reset release.
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en     <= 1'b0;
            w_q        <= '0;
            h_q        <= '0;
            n_q        <= '0;
            wr_addr    <= '0;
            sx         <= '0;
            sy         <= '0;
            pixel_data <= '0;
        end else begin
            rdy_en     <= 1'b1;
            pixel_data <= (32'(pixel_addr) < DEPTH) ? mem[pixel_addr] : 8'h00;
            if (state == GET_W && accept) w_q <= in_data;
            if (state == GET_H && accept) begin
                h_q     <= in_data;
                n_q     <= prod;
                wr_addr <= '0;
            end
            if (state == LOAD && accept) wr_addr <= wr_addr + ADDR_W'(1);
            if (state == COMMIT) begin
                sx <= w_q;
                sy <= h_q - 8'd1;
            end
        end
    end

    // NOTE: the frame RAM is deliberately not reset so it can map onto block RAM; contents survive rst_n.
    always_ff @(posedge clk25) begin
        if (state == LOAD && accept) mem[wr_addr] <= in_data;
    end

endmodule

// File: tb/tb_frame_loader.sv
// Randomized bench for frame_loader: drives packets with junk and valid gaps, and checks extent,
// pulses and RAM contents against a packet-level model of the image.
module tb_frame_loader;

    localparam int         DEPTH  = 8192;
    localparam int         ADDR_W = 13;
    localparam logic [7:0] SYNC   = 8'hA5;

    logic              clk25 = 1'b0;
    logic              rst_n;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] pixel_addr;
    logic [7:0]        pixel_data, sx, sy;
    logic              frame_done, load_err;

    frame_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .SYNC(SYNC)) dut (
        .clk25(clk25), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
        .sx(sx), .sy(sy), .frame_done(frame_done), .load_err(load_err)
    );

    always #20 clk25 = ~clk25;

    int         n_cmp = 0, n_err = 0;
    int         cnt_done = 0, cnt_err = 0, exp_done = 0, exp_err = 0;
    logic [7:0] model_mem [DEPTH];
    bit         written   [DEPTH];
    logic [7:0] exp_sx = 8'd0, exp_sy = 8'd0;
    logic [7:0] pix_q [$];

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Pulse monitor: counts commits/rejects and checks the stream is stalled during each.
    always @(negedge clk25) begin
        if (frame_done) begin
            cnt_done++;
            check("done_rdy_mon", in_ready, 0);
        end
        if (load_err) begin
            cnt_err++;
            check("err_rdy_mon", in_ready, 0);
        end
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        logic rdy;
        in_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; ; t++) begin
            if (t >= 20) begin
                check("ready_timeout", 0, 1);
                break;
            end
            rdy = in_ready;
            step();
            if (rdy) break;
        end
        in_valid = 1'b0;
    endtask

    task automatic read_check(input int addr);
        pixel_addr = ADDR_W'(addr);
        step();
        if (written[addr]) check($sformatf("rd[%0d]", addr), pixel_data, model_mem[addr]);
    endtask

    // One packet; pixels come from pix_q when it holds any, otherwise random.
    task automatic send_frame(input logic [7:0] w, input logic [7:0] h, input int gapmax);
        int         n;
        int         ra;
        logic [7:0] b, old_val;
        bit         old_known;
        n = int'(w) * int'(h);
        send_byte(SYNC, $urandom_range(0, gapmax));
        send_byte(w, $urandom_range(0, gapmax));
        send_byte(h, $urandom_range(0, gapmax));
        if (w == 0 || h == 0 || n > DEPTH) begin
            exp_err++;
            check("err_pulse", load_err, 1);
            check("err_rdy", in_ready, 0);
            step();
            check("err_clear", load_err, 0);
            check("err_keep_sx", sx, exp_sx);
            check("err_keep_sy", sy, exp_sy);
            check("err_rdy_back", in_ready, 1);
            return;
        end
        ra        = int'(pixel_addr);
        old_known = 1'b0;
        old_val   = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = (pix_q.size() > 0) ? pix_q.pop_front() : 8'($urandom_range(0, 255));
            if (i == n - 1) begin
                old_known = written[ra];
                old_val   = model_mem[ra];
            end
            send_byte(b, $urandom_range(0, gapmax));
            model_mem[i] = b;
            written[i]   = 1'b1;
        end
        exp_done++;
        exp_sx = w;
        exp_sy = h - 8'd1;
        check("done_pulse", frame_done, 1);
        check("done_rdy", in_ready, 0);
        if (old_known) check("rd_first_old", pixel_data, old_val);
        step();
        check("done_clear", frame_done, 0);
        check("sx", sx, exp_sx);
        check("sy", sy, exp_sy);
        if (written[ra]) check("rd_after_wr", pixel_data, model_mem[ra]);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w, h, j;
        int         n;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        pixel_addr = '0;
        for (int i = 0; i < DEPTH; i++) written[i] = 1'b0;

        step();
        step();
        check("rst_ready", in_ready, 0);
        check("rst_pixel", pixel_data, 0);
        check("rst_sx", sx, 0);
        check("rst_sy", sy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", load_err, 0);
        rst_n = 1'b1;
        #1;
        check("rel_ready_low", in_ready, 0);
        step();
        check("rel_ready_high", in_ready, 1);

        // Basic 2x2 image
        pix_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(8'd2, 8'd2, 0);
        for (int a = 0; a < 4; a++) read_check(a);

        // Full-depth image 128x64
        send_frame(8'd128, 8'd64, 0);
        read_check(DEPTH - 1);
        read_check(0);

        // Rejected headers keep the previous extent; next header loads
        send_frame(8'd0, 8'd5, 0);
        send_frame(8'h81, 8'h40, 0);
        pix_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_frame(8'd2, 8'd2, 1);

        // Read-first: hold address 3 while it is rewritten with 99
        pixel_addr = ADDR_W'(3);
        pix_q = '{8'h55, 8'h66, 8'h77, 8'h99};
        send_frame(8'd2, 8'd2, 0);
        read_check(3);

        // Junk before SYNC, gaps in LOAD, SYNC value as pixel data
        send_byte(8'h00, 0);
        send_byte(8'hFF, 2);
        pix_q = '{8'hA5, 8'hA5, 8'h07};
        send_frame(8'd3, 8'd1, 3);
        for (int a = 0; a < 3; a++) read_check(a);

        // Reset after 2 of 4 pixels
        send_byte(SYNC, 0);
        send_byte(8'd2, 0);
        send_byte(8'd2, 0);
        send_byte(8'hC1, 0);
        send_byte(8'hC2, 1);
        model_mem[0] = 8'hC1;
        model_mem[1] = 8'hC2;
        rst_n = 1'b0;
        #1;
        exp_sx = 8'd0;
        exp_sy = 8'd0;
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_sx", sx, 0);
        check("mid_rst_sy", sy, 0);
        check("mid_rst_pixel", pixel_data, 0);
        check("mid_rst_done", frame_done, 0);
        step();
        rst_n = 1'b1;
        step();
        read_check(1);
        read_check(0);
        send_frame(8'd2, 8'd2, 1);
        for (int a = 0; a < 4; a++) read_check(a);

        // Randomized packets
        for (int it = 0; it < 25; it++) begin
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                j = 8'($urandom_range(0, 255));
                if (j == SYNC) j = 8'h00;
                send_byte(j, $urandom_range(0, 2));
            end
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin w = 8'd0; h = 8'($urandom_range(1, 255)); end
                    1:       begin w = 8'($urandom_range(1, 255)); h = 8'd0; end
                    default: begin w = 8'd255; h = 8'($urandom_range(33, 255)); end
                endcase
            end else begin
                w = 8'($urandom_range(1, 12));
                h = 8'($urandom_range(1, 12));
            end
            send_frame(w, h, 2);
            n = int'(w) * int'(h);
            if (w != 0 && h != 0 && n <= DEPTH) begin
                for (int r = 0; r < 3; r++) read_check($urandom_range(0, n - 1));
            end
        end

        step();
        check("done_count", cnt_done, exp_done);
        check("err_count", cnt_err, exp_err);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
